z80_bus_responder: RTL and testbench
====================================

# z80_bus_responder

Z80 bus target that sits opposite the on-chip Z80 CPU, on the same bus and clock. It answers CPU memory cycles to a small internal RAM window and I/O cycles to three port registers, inserting programmable wait states. It also acts as a single-source IM2 interrupt controller: it raises `int_n` and supplies the vector during the M1+IORQ acknowledge cycle.

## Interface
- `MEM_AW`, 6: RAM window address width (2^MEM_AW bytes).
- `MEM_BASE`, 16'h8000: window base; must be aligned to 2^MEM_AW.
- `IO_BASE`, 8'h10: base of the 3-port I/O block (`addr[7:0]`).
- `WAIT_STATES`, 1: `wait_n`-low cycles inserted per RAM read, 0..15.
- `wb_clk_i`  in  1  clock, shared with the CPU.
- `wb_rst_i`  in  1  asynchronous, active-high reset.
- `addr`  in  16  CPU address bus.
- `di`  in  8  CPU write data.
- `m1_n`, `mreq_n`, `iorq_n`, `rd_n`, `wr_n`, `rfsh_n`  in  1 each  CPU bus controls.
- `irq`  in  1  peripheral interrupt request; its rising edge sets pending.
- `dout`  out  8  read data or vector.
- `doe`  out  1  data-bus drive enable.
- `wait_n`  out  1  to CPU WAIT.
- `int_n`  out  1  to CPU INT.
- `port_q`  out  8  port 0 data register, exported to the pad logic.

## Operation
- All bus inputs are sampled on the rising edge of `wb_clk_i`. All outputs are registered.
- Decode terms:
  - mem hit: `addr[15:MEM_AW]==MEM_BASE[15:MEM_AW]`, `mreq_n=0`, `rfsh_n=1`.
  - io hit: `iorq_n=0`, `m1_n=1`, and `addr[7:0]` equals `IO_BASE+0`, `+1` or `+2`.
  - ack: `m1_n=0` and `iorq_n=0`.
- The FSM has five states: IDLE, WAIT, DRIVE, WHOLD, RELEASE.
- From IDLE:
  - mem hit with `rd_n=0`:
    - If `WAIT_STATES>0`, go to WAIT, set `wait_n=0`, load counter=`WAIT_STATES-1`.
    - If `WAIT_STATES=0`, go to DRIVE.
  - mem hit with `wr_n=0`: write `mem[addr[MEM_AW-1:0]]<=di` on this edge, go to WHOLD.
  - io hit with `rd_n=0`: go to DRIVE and load the port value.
  - io hit with `wr_n=0`: write the port, go to WHOLD.
  - ack: go to DRIVE, set `dout<=vector`, clear pending.
- WAIT: decrement the counter. At 0, set `wait_n<=1`, load `dout` with RAM data, go to DRIVE.
- DRIVE: `doe=1`, `dout` is held. When `rd_n=1` or the strobe (`mreq_n`/`iorq_n`) is 1, go to RELEASE with `doe<=0`.
- WHOLD: wait for `wr_n=1`, then go to IDLE. Exactly one write per bus cycle.
- RELEASE: one cycle, then IDLE. This guarantees at least one cycle with `doe=0` between back-to-back reads.
- Ports:
  - +0 `port_q`: R/W.
  - +1 vector: R/W.
  - +2 ctrl: bit0 = IRQ enable (R/W); bit1 = pending (R; writing 1 clears it); bits 7:2 read 0.
- `int_n = ~(pending & enable)`, registered.
- Pending is set on a registered rising edge of `irq` while `enable=1`. If the set and an ack or W1C clear happen in the same cycle, the set wins.
- Misses never assert `doe` or `wait_n`.
- Refresh cycles (`rfsh_n=0`) are ignored.

## Timing
- Reset values: `dout=0`, `doe=0`, `wait_n=1`, `int_n=1`, `port_q=0`, vector=8'hFF, ctrl=0, state=IDLE.
- RAM contents are not reset.
- Latency from the sampling edge where a hit is decoded:
  - `doe` rises 1 cycle later for I/O, ack, and `WAIT_STATES=0` reads.
  - With `WAIT_STATES=N`, `wait_n` is low for N cycles and `doe` rises with `wait_n` returning high.
- `int_n` falls 2 cycles after the `irq` rising edge: edge register, then output register.
- `int_n` rises 1 cycle after the ack is decoded.
- Reset asserted mid-cycle immediately forces all outputs to their reset values. After reset, the FSM re-arms only once all strobes are seen high. The FSM does not join a cycle already in progress.

## Configuration
- `Z80_RESP_IRQ_EN` defined: the interrupt controller, ack response and ports +1/+2 are present.
- `Z80_RESP_IRQ_EN` undefined:
  - `int_n` is tied to 1 and `irq` is ignored.
  - Ack cycles are not answered (`doe` stays 0).
  - Ports +1/+2 are not decoded (no `doe`); writes to them are dropped.

## Structure
- Shared package `z80_resp_pkg` holds:
  - the state enum (IDLE, WAIT, DRIVE, WHOLD, RELEASE);
  - port offset constants `PORT_DATA=0`, `PORT_VEC=1`, `PORT_CTRL=2`;
  - the ctrl bit indices.
- One sub-module, `z80_resp_irq`, contains the edge detect, pending/enable/vector registers and the `int_n` register. It is instantiated only under `Z80_RESP_IRQ_EN`.

## Test plan
- Memory write then read: write 8'hA5 to 16'h8003, then read 16'h8003 with `WAIT_STATES=1`. Expect `wait_n` low for exactly 1 cycle, then `doe=1` with `dout=8'hA5`, and `doe=0` one cycle after `rd_n` rises.
- I/O port: write 8'h3C to port 8'h10. Expect `port_q=8'h3C` the next cycle. A read of port 8'h10 returns 8'h3C with `doe` 1 cycle after decode and no wait.
- Interrupt acknowledge:
  - Write vector 8'h40 and ctrl 8'h01, then pulse `irq`. Expect `int_n=0` 2 cycles later.
  - On the M1+IORQ ack cycle, expect `dout=8'h40` and `doe=1`; `int_n` returns to 1 and ctrl reads 8'h01.
- Misses and refresh:
  - Read 16'h7FFF: expect no `doe` and no `wait_n`.
  - Refresh with `addr=16'h8000`, `rfsh_n=0`: expect no `doe` and no `wait_n`.
- Reset mid-read: assert `wb_rst_i` during WAIT. Expect `wait_n=1` and `doe=0` immediately, and no drive when the old cycle completes after reset is released.
- Simultaneous events: `irq` rising edge in the same cycle as a W1C write to ctrl. Expect pending to remain 1 and `int_n` to stay 0.

Source files
------------

// File: rtl/z80_resp_pkg.sv
// rtl/z80_resp_pkg.sv - shared FSM states, port offsets and ctrl bit indices for the Z80 bus responder
package z80_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DRIVE,
    ST_WHOLD,
    ST_RELEASE
  } state_t;

  localparam logic [7:0] PORT_DATA = 8'd0;
  localparam logic [7:0] PORT_VEC  = 8'd1;
  localparam logic [7:0] PORT_CTRL = 8'd2;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_PEND = 1;

endpackage

// File: rtl/z80_bus_responder_if.sv
// rtl/z80_bus_responder_if.sv - Z80 CPU bus bundle between the CPU side and the responder
interface z80_bus_responder_if;
  logic [15:0] addr;
  logic [7:0]  di;
  logic        m1_n;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        rfsh_n;
  logic        irq;
  logic [7:0]  dout;
  logic        doe;
  logic        wait_n;
  logic        int_n;
  logic [7:0]  port_q;

  modport master (
    output addr, di, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, irq,
    input  dout, doe, wait_n, int_n, port_q
  );

  modport slave (
    input  addr, di, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, irq,
    output dout, doe, wait_n, int_n, port_q
  );
endinterface

// File: rtl/z80_resp_irq.sv
// rtl/z80_resp_irq.sv - IM2 single-source interrupt controller, built only under Z80_RESP_IRQ_EN
module z80_resp_irq
  import z80_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       irq,
  input  logic       vec_we,
  input  logic       ctrl_we,
  input  logic       ack,
  input  logic [7:0] wdata,
  output logic [7:0] vector,
  output logic [7:0] ctrl,
  output logic       int_n
);
  logic irq_d;
  logic pending;
  logic enable;
  logic set;

  // A new edge beats a same-cycle ack or write-one-to-clear.
  assign set  = irq & ~irq_d & enable;
  assign ctrl = {6'b0, pending, enable};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_d   <= 1'b0;
      pending <= 1'b0;
      enable  <= 1'b0;
      vector  <= 8'hFF;
      int_n   <= 1'b1;
    end else begin
      irq_d <= irq;
      if (vec_we)
        vector <= wdata;
      if (ctrl_we)
        enable <= wdata[CTRL_EN];
      if (set)
        pending <= 1'b1;
      else if (ack || (ctrl_we && wdata[CTRL_PEND]))
        pending <= 1'b0;
      int_n <= ~(pending & enable);
    end
  end

endmodule

// File: rtl/z80_bus_responder.sv
// rtl/z80_bus_responder.sv - Z80 bus target: RAM window, I/O ports, programmable read wait states
// Define Z80_RESP_IRQ_EN for the IM2 interrupt controller, ack response and ports +1/+2.
module z80_bus_responder
  import z80_resp_pkg::*;
#(
  parameter int          MEM_AW      = 6,
  parameter logic [15:0] MEM_BASE    = 16'h8000,
  parameter logic [7:0]  IO_BASE     = 8'h10,
  parameter int          WAIT_STATES = 1
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  z80_bus_responder_if.slave bus
);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [7:0] mem [2**MEM_AW];

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [7:0]        dout_q, dout_nxt, port_q, vec_val, ctrl_val, port_rd, io_off;
  logic              doe_q, doe_nxt, wait_q, wait_nxt, cyc_ack, cyc_ack_nxt, armed;
  logic              mem_hit, io_hit, ack_hit, mem_we, port_we, ack_clr, strobes_idle;
  logic              drive_done;
  logic [MEM_AW-1:0] mem_idx;

  assign mem_idx      = bus.addr[MEM_AW-1:0];
  assign io_off       = bus.addr[7:0] - IO_BASE;
  assign mem_hit      = (bus.addr[15:MEM_AW] == MEM_BASE[15:MEM_AW]) && !bus.mreq_n && bus.rfsh_n;
  assign strobes_idle = bus.mreq_n & bus.iorq_n & bus.rd_n & bus.wr_n;
`ifdef Z80_RESP_IRQ_EN
  assign io_hit  = !bus.iorq_n && bus.m1_n && (io_off <= PORT_CTRL);
  assign ack_hit = !bus.m1_n && !bus.iorq_n;
`else
  assign io_hit  = !bus.iorq_n && bus.m1_n && (io_off == PORT_DATA);
  assign ack_hit = 1'b0;
`endif

  // An ack cycle has rd_n high throughout, so it ends on IORQ/M1 instead.
  assign drive_done = cyc_ack ? (bus.iorq_n | bus.m1_n)
                              : (bus.rd_n | (bus.mreq_n & bus.iorq_n));

  always_comb begin
    port_rd = port_q;
    if (io_off == PORT_VEC)
      port_rd = vec_val;
    else if (io_off == PORT_CTRL)
      port_rd = ctrl_val;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    dout_nxt    = dout_q;
    doe_nxt     = doe_q;
    wait_nxt    = wait_q;
    cyc_ack_nxt = cyc_ack;
    mem_we      = 1'b0;
    port_we     = 1'b0;
    ack_clr     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (armed) begin
          if (mem_hit && !bus.rd_n) begin
            cyc_ack_nxt = 1'b0;
            if (WAIT_STATES > 0) begin
              state_nxt = ST_WAIT;
              wait_nxt  = 1'b0;
              cnt_nxt   = WS - 4'd1;
            end else begin
              state_nxt = ST_DRIVE;
              doe_nxt   = 1'b1;
              dout_nxt  = mem[mem_idx];
            end
          end else if (mem_hit && !bus.wr_n) begin
            mem_we    = 1'b1;
            state_nxt = ST_WHOLD;
          end else if (io_hit && !bus.rd_n) begin
            state_nxt   = ST_DRIVE;
            doe_nxt     = 1'b1;
            dout_nxt    = port_rd;
            cyc_ack_nxt = 1'b0;
          end else if (io_hit && !bus.wr_n) begin
            port_we   = 1'b1;
            state_nxt = ST_WHOLD;
          end else if (ack_hit) begin
            state_nxt   = ST_DRIVE;
            doe_nxt     = 1'b1;
            dout_nxt    = vec_val;
            cyc_ack_nxt = 1'b1;
            ack_clr     = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          wait_nxt  = 1'b1;
          doe_nxt   = 1'b1;
          dout_nxt  = mem[mem_idx];
          state_nxt = ST_DRIVE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_DRIVE: begin
        if (drive_done) begin
          doe_nxt   = 1'b0;
          state_nxt = ST_RELEASE;
        end
      end
      ST_WHOLD: begin
        if (bus.wr_n)
          state_nxt = ST_IDLE;
      end
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // armed stays low after reset until every strobe has been seen high once.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      dout_q  <= 8'h00;
      doe_q   <= 1'b0;
      wait_q  <= 1'b1;
      cyc_ack <= 1'b0;
      armed   <= 1'b0;
      port_q  <= 8'h00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      dout_q  <= dout_nxt;
      doe_q   <= doe_nxt;
      wait_q  <= wait_nxt;
      cyc_ack <= cyc_ack_nxt;
      armed   <= armed | strobes_idle;
      if (port_we && io_off == PORT_DATA)
        port_q <= bus.di;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (mem_we)
      mem[mem_idx] <= bus.di;
  end

  assign bus.dout   = dout_q;
  assign bus.doe    = doe_q;
  assign bus.wait_n = wait_q;
  assign bus.port_q = port_q;

`ifdef Z80_RESP_IRQ_EN
  z80_resp_irq u_irq (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .irq     (bus.irq),
    .vec_we  (port_we && io_off == PORT_VEC),
    .ctrl_we (port_we && io_off == PORT_CTRL),
    .ack     (ack_clr),
    .wdata   (bus.di),
    .vector  (vec_val),
    .ctrl    (ctrl_val),
    .int_n   (bus.int_n)
  );
`else
  logic unused_irq;
  assign vec_val    = 8'hFF;
  assign ctrl_val   = 8'h00;
  assign bus.int_n  = 1'b1;
  assign unused_irq = bus.irq ^ ack_clr;
`endif

endmodule

// File: tb/tb_z80_bus_responder.sv
// tb/tb_z80_bus_responder.sv - randomized self-checking bench for z80_bus_responder
module tb_z80_bus_responder;
`ifdef Z80_RESP_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  localparam int         WS  = 1;
  localparam logic [7:0] IOB = 8'h10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [7:0] ram_m [64];
  bit         ram_v [64];
  logic [7:0] port_m = 8'h00;
  logic [7:0] vec_m = 8'hFF;
  bit         en_m = 1'b0;
  bit         pend_m = 1'b0;

  z80_bus_responder_if bus ();

  z80_bus_responder #(
    .MEM_AW      (6),
    .MEM_BASE    (16'h8000),
    .IO_BASE     (IOB),
    .WAIT_STATES (WS)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit int_exp();
    return IRQ ? ~(pend_m & en_m) : 1'b1;
  endfunction

  function automatic bit io_hit(input logic [7:0] p);
    logic [7:0] off;
    off = p - IOB;
    return (off == 8'd0) || (IRQ && off < 8'd3);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.mreq_n = 1'b1;
    bus.iorq_n = 1'b1;
    bus.rd_n   = 1'b1;
    bus.wr_n   = 1'b1;
    bus.m1_n   = 1'b1;
    bus.rfsh_n = 1'b1;
  endtask

  task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
    bus.addr   = a;
    bus.di     = d;
    bus.mreq_n = 1'b0;
    bus.wr_n   = 1'b0;
    if (a[15:6] == 10'h200) begin
      ram_m[a[5:0]] = d;
      ram_v[a[5:0]] = 1'b1;
    end
    tick();
    check("wr_wait_n", 16'(bus.wait_n), 16'(1));
    check("wr_doe", 16'(bus.doe), 16'(0));
    tick();
    idle_bus();
    tick();
    tick();
  endtask

  task automatic mem_read(input logic [15:0] a, input bit rfsh);
    int         n;
    bit         hit;
    logic [7:0] exp;
    hit = (a[15:6] == 10'h200) && !rfsh;
    exp = ram_m[a[5:0]];
    bus.addr   = a;
    bus.mreq_n = 1'b0;
    bus.rd_n   = 1'b0;
    bus.rfsh_n = ~rfsh;
    tick();
    n = 0;
    while (!bus.wait_n && n < 20) begin
      n++;
      tick();
    end
    check("rd_wait_cycles", 16'(n), 16'(hit ? WS : 0));
    check("rd_doe", 16'(bus.doe), 16'(hit));
    if (hit)
      check("rd_data", 16'(bus.dout), 16'(exp));
    tick();
    check("rd_hold_doe", 16'(bus.doe), 16'(hit));
    idle_bus();
    tick();
    check("rd_release_doe", 16'(bus.doe), 16'(0));
    tick();
  endtask

  task automatic io_write(input logic [7:0] p, input logic [7:0] d, input bit rise);
    logic [7:0] off;
    bit         ib;
    bit         old_en;
    ib     = int_exp();
    off    = p - IOB;
    old_en = en_m;
    bus.addr   = {8'h00, p};
    bus.di     = d;
    bus.iorq_n = 1'b0;
    bus.wr_n   = 1'b0;
    if (rise)
      bus.irq = 1'b1;
    if (io_hit(p)) begin
      if (off == 8'd0)
        port_m = d;
      else if (off == 8'd1)
        vec_m = d;
      else begin
        en_m = d[0];
        if (d[1])
          pend_m = 1'b0;
      end
    end
    if (IRQ && rise && old_en)
      pend_m = 1'b1;
    tick();
    check("io_port_q", 16'(bus.port_q), 16'(port_m));
    check("io_wr_int_n", 16'(bus.int_n), 16'(ib));
    check("io_wr_doe", 16'(bus.doe), 16'(0));
    tick();
    idle_bus();
    bus.irq = 1'b0;
    tick();
    tick();
    check("io_wr_int_n_after", 16'(bus.int_n), 16'(int_exp()));
  endtask

  task automatic io_read(input logic [7:0] p);
    logic [7:0] off;
    logic [7:0] exp;
    bit         hit;
    off = p - IOB;
    hit = io_hit(p);
    exp = (off == 8'd0) ? port_m : (off == 8'd1) ? vec_m : {6'b0, pend_m, en_m};
    bus.addr   = {8'h00, p};
    bus.iorq_n = 1'b0;
    bus.rd_n   = 1'b0;
    tick();
    check("io_rd_doe", 16'(bus.doe), 16'(hit));
    check("io_rd_wait_n", 16'(bus.wait_n), 16'(1));
    if (hit)
      check("io_rd_data", 16'(bus.dout), 16'(exp));
    idle_bus();
    tick();
    check("io_rd_release", 16'(bus.doe), 16'(0));
    tick();
  endtask

  task automatic ack_cycle();
    bus.m1_n   = 1'b0;
    bus.iorq_n = 1'b0;
    tick();
    check("ack_doe", 16'(bus.doe), 16'(IRQ));
    if (IRQ) begin
      check("ack_vector", 16'(bus.dout), 16'(vec_m));
      pend_m = 1'b0;
    end
    tick();
    check("ack_int_n", 16'(bus.int_n), 16'(int_exp()));
    idle_bus();
    tick();
    check("ack_release", 16'(bus.doe), 16'(0));
    tick();
  endtask

  task automatic irq_pulse();
    bit ib;
    ib = int_exp();
    bus.irq = 1'b1;
    tick();
    check("irq_e0_int_n", 16'(bus.int_n), 16'(ib));
    if (IRQ && en_m)
      pend_m = 1'b1;
    tick();
    check("irq_e1_int_n", 16'(bus.int_n), 16'(int_exp()));
    bus.irq = 1'b0;
    tick();
  endtask

  initial begin
    int         idx;
    logic [15:0] a;
    idle_bus();
    bus.addr = 16'h0000;
    bus.di   = 8'h00;
    bus.irq  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", 16'(bus.dout), 16'(0));
    check("rst_doe", 16'(bus.doe), 16'(0));
    check("rst_wait_n", 16'(bus.wait_n), 16'(1));
    check("rst_int_n", 16'(bus.int_n), 16'(1));
    check("rst_port_q", 16'(bus.port_q), 16'(0));
    rst = 1'b0;
    tick();

    mem_write(16'h8003, 8'hA5);
    mem_read(16'h8003, 1'b0);
    io_write(8'h10, 8'h3C, 1'b0);
    io_read(8'h10);
    io_write(8'h11, 8'h40, 1'b0);
    io_write(8'h12, 8'h01, 1'b0);
    irq_pulse();
    ack_cycle();
    io_read(8'h12);
    io_read(8'h11);
    mem_read(16'h7FFF, 1'b0);
    mem_read(16'h8000, 1'b1);
    irq_pulse();
    io_write(8'h12, 8'h03, 1'b1);
    io_read(8'h12);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: mem_write(16'h8000 + 16'($urandom_range(0, 63)), 8'($urandom));
        1: begin
          idx = $urandom_range(0, 63);
          if (ram_v[idx])
            mem_read(16'h8000 + 16'(idx), 1'b0);
          else
            mem_write(16'h8000 + 16'(idx), 8'($urandom));
        end
        2: begin
          a = $urandom_range(0, 1) ? 16'($urandom_range(0, 32767))
                                   : 16'($urandom_range(32832, 65535));
          mem_read(a, 1'b0);
        end
        3: io_write(8'($urandom_range(15, 19)), 8'($urandom), 1'b0);
        4: io_read(8'($urandom_range(15, 19)));
        default: begin
          if ($urandom_range(0, 1) == 1)
            irq_pulse();
          else
            ack_cycle();
        end
      endcase
    end

    mem_write(16'h8003, 8'hA5);
    bus.addr   = 16'h8003;
    bus.mreq_n = 1'b0;
    bus.rd_n   = 1'b0;
    tick();
    check("mid_rst_pre_wait_n", 16'(bus.wait_n), 16'(0));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wait_n", 16'(bus.wait_n), 16'(1));
    check("mid_rst_doe", 16'(bus.doe), 16'(0));
    check("mid_rst_int_n", 16'(bus.int_n), 16'(1));
    check("mid_rst_port_q", 16'(bus.port_q), 16'(0));
    port_m = 8'h00;
    vec_m  = 8'hFF;
    en_m   = 1'b0;
    pend_m = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_doe", 16'(bus.doe), 16'(0));
      check("post_rst_no_wait", 16'(bus.wait_n), 16'(1));
    end
    idle_bus();
    tick();
    tick();
    mem_read(16'h8003, 1'b0);
    io_read(8'h11);
    io_read(8'h12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
